// File: rtl/fsic_is_rx_buffer.sv
// Receive-side elastic buffer behind the IO SERDES Rx path (axis_clk domain).
// The input is push-only because the SERDES cannot be stalled. The buffer
// presents an AXI-Stream master downstream and produces a registered
// credit-style ready (fc_tready) that is serialised back to the remote sender.
module fsic_is_rx_buffer #(
   parameter int pDATA_WIDTH   = 32,
   parameter int pFIFO_DEPTH   = 8,
   parameter int pFC_THRESHOLD = 3
) (
   input  logic                             axis_clk,
   input  logic                             axis_rst_n,
   input  logic                             rx_en,
   input  logic [pDATA_WIDTH-1:0]           in_tdata,
   input  logic [pDATA_WIDTH/8-1:0]         in_tstrb,
   input  logic [pDATA_WIDTH/8-1:0]         in_tkeep,
   input  logic                             in_tlast,
   input  logic [1:0]                       in_tid,
   input  logic [1:0]                       in_tuser,
   input  logic                             in_tvalid,
   output logic [pDATA_WIDTH-1:0]           out_tdata,
   output logic [pDATA_WIDTH/8-1:0]         out_tstrb,
   output logic [pDATA_WIDTH/8-1:0]         out_tkeep,
   output logic                             out_tlast,
   output logic [1:0]                       out_tid,
   output logic [1:0]                       out_tuser,
   output logic                             out_tvalid,
   input  logic                             out_tready,
   output logic                             fc_tready,
   output logic [$clog2(pFIFO_DEPTH):0]     fifo_count,
   output logic                             overflow,
   input  logic                             overflow_clr
);

   localparam int SW = pDATA_WIDTH / 8;
   localparam int AW = $clog2(pFIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = pDATA_WIDTH + 2 * SW + 5;

   localparam logic [CW-1:0] DEPTH_C = CW'(pFIFO_DEPTH);
   localparam logic [CW-1:0] THRESH_C = CW'(pFC_THRESHOLD);

   logic [PW-1:0] mem [pFIFO_DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          fc_q, fc_d;
   logic          ovf_q, ovf_d;

   logic          push_req;
   logic          pop;
   logic          push;
   logic          drop;
   logic [CW-1:0] free_next;
   logic [PW-1:0] wr_payload;
   logic [PW-1:0] rd_payload;

   // Push/pop decisions, pointer/count update and next flow-control credit.
   always_comb begin
      push_req   = in_tvalid & rx_en;
      pop        = (count_q != '0) & out_tready;
      // A full FIFO can still take a beat when the head leaves in the same cycle.
      push       = push_req & ((count_q < DEPTH_C) | pop);
      drop       = push_req & ~push;
      wr_payload = {in_tlast, in_tid, in_tuser, in_tkeep, in_tstrb, in_tdata};

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      // Credit is withdrawn once the post-update free space no longer covers
      // the beats the remote may already have in flight.
      free_next = DEPTH_C - count_d;
      fc_d      = (free_next > THRESH_C);

      // A drop in the same cycle as a clear wins so no loss goes unreported.
      ovf_d = ovf_q;
      if (drop)              ovf_d = 1'b1;
      else if (overflow_clr) ovf_d = 1'b0;
   end

   // Control state: pointers, occupancy, flow-control credit, sticky overflow.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fc_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         fc_q     <= fc_d;
         ovf_q    <= ovf_d;
      end
   end

   // Payload storage; contents are deliberately left unreset.
   always_ff @(posedge axis_clk) begin
      if (push) mem[wr_ptr_q] <= wr_payload;
   end

   // First-word fall-through: the head entry drives the outputs directly.
   assign rd_payload = mem[rd_ptr_q];
   assign {out_tlast, out_tid, out_tuser, out_tkeep, out_tstrb, out_tdata} = rd_payload;

   assign out_tvalid = (count_q != '0);
   assign fc_tready  = fc_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_fsic_is_rx_buffer.sv
// Directed self-checking bench for fsic_is_rx_buffer (default parameters).
module tb_fsic_is_rx_buffer;

   logic        axis_clk;
   logic        axis_rst_n;
   logic        rx_en;
   logic [31:0] in_tdata;
   logic [3:0]  in_tstrb;
   logic [3:0]  in_tkeep;
   logic        in_tlast;
   logic [1:0]  in_tid;
   logic [1:0]  in_tuser;
   logic        in_tvalid;
   logic [31:0] out_tdata;
   logic [3:0]  out_tstrb;
   logic [3:0]  out_tkeep;
   logic        out_tlast;
   logic [1:0]  out_tid;
   logic [1:0]  out_tuser;
   logic        out_tvalid;
   logic        out_tready;
   logic        fc_tready;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic        overflow_clr;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   fsic_is_rx_buffer #(
      .pDATA_WIDTH  (32),
      .pFIFO_DEPTH  (8),
      .pFC_THRESHOLD(3)
   ) dut (
      .axis_clk    (axis_clk),
      .axis_rst_n  (axis_rst_n),
      .rx_en       (rx_en),
      .in_tdata    (in_tdata),
      .in_tstrb    (in_tstrb),
      .in_tkeep    (in_tkeep),
      .in_tlast    (in_tlast),
      .in_tid      (in_tid),
      .in_tuser    (in_tuser),
      .in_tvalid   (in_tvalid),
      .out_tdata   (out_tdata),
      .out_tstrb   (out_tstrb),
      .out_tkeep   (out_tkeep),
      .out_tlast   (out_tlast),
      .out_tid     (out_tid),
      .out_tuser   (out_tuser),
      .out_tvalid  (out_tvalid),
      .out_tready  (out_tready),
      .fc_tready   (fc_tready),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .overflow_clr(overflow_clr)
   );

   initial axis_clk = 1'b0;
   always #5 axis_clk = ~axis_clk;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Advance one clock; return 1 time unit after the edge.
   task automatic tick();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic set_beat(input logic v, input logic [31:0] d, input logic l,
                           input logic [1:0] id, input logic [1:0] u);
      in_tvalid = v;
      in_tdata  = d;
      in_tlast  = l;
      in_tid    = id;
      in_tuser  = u;
      in_tstrb  = 4'hF;
      in_tkeep  = 4'hF;
   endtask

   initial begin
      axis_rst_n   = 1'b0;
      rx_en        = 1'b1;
      out_tready   = 1'b0;
      overflow_clr = 1'b0;
      set_beat(1'b0, 32'h0, 1'b0, 2'd0, 2'd0);

      // ---- Reset state and release ----
      repeat (3) tick();
      check("rst_tvalid", out_tvalid, 1'b0);
      check("rst_count", fifo_count, 4'd0);
      check("rst_fc", fc_tready, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      axis_rst_n = 1'b1;
      #1;
      check("rel_fc_before_edge", fc_tready, 1'b0);
      tick();
      check("rel_fc_after_edge", fc_tready, 1'b1);
      check("rel_tvalid", out_tvalid, 1'b0);

      // ---- rx_en=0 ignores pushes ----
      rx_en = 1'b0;
      set_beat(1'b1, 32'hDEADBEEF, 1'b0, 2'd0, 2'd0);
      tick();
      check("rxdis_count", fifo_count, 4'd0);
      check("rxdis_ovf", overflow, 1'b0);
      rx_en = 1'b1;

      // ---- Three beats, streaming with out_tready=1 ----
      out_tready = 1'b1;
      set_beat(1'b1, 32'h11111111, 1'b0, 2'd2, 2'd1);
      tick();
      check("s1_tvalid", out_tvalid, 1'b1);
      check("s1_data", out_tdata, 32'h11111111);
      check("s1_last", out_tlast, 1'b0);
      check("s1_strb_keep", {out_tstrb, out_tkeep}, 8'hFF);
      set_beat(1'b1, 32'h22222222, 1'b0, 2'd2, 2'd1);
      tick();
      check("s2_data", out_tdata, 32'h22222222);
      check("s2_count", fifo_count, 4'd1);
      set_beat(1'b1, 32'h33333333, 1'b1, 2'd2, 2'd1);
      tick();
      check("s3_data", out_tdata, 32'h33333333);
      check("s3_last", out_tlast, 1'b1);
      check("s3_tid", out_tid, 2'd2);
      check("s3_tuser", out_tuser, 2'd1);
      set_beat(1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
      tick();
      check("s_end_count", fifo_count, 4'd0);
      check("s_end_tvalid", out_tvalid, 1'b0);

      // ---- Five beats with out_tready=0: flow control threshold ----
      out_tready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         set_beat(1'b1, 32'hA0 + 32'(i), 1'b0, 2'd0, 2'd0);
         tick();
         check($sformatf("fc_count%0d", i), fifo_count, 4'(i));
         check($sformatf("fc_ready%0d", i), fc_tready, (i <= 4) ? 1'b1 : 1'b0);
         check($sformatf("fc_hold%0d", i), out_tdata, 32'hA1);
      end
      set_beat(1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
      out_tready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("fc_drain%0d", i), out_tdata, 32'hA0 + 32'(i));
         tick();
      end
      check("fc_drain_count", fifo_count, 4'd0);
      check("fc_drain_ready", fc_tready, 1'b1);

      // ---- Nine beats into an 8-deep FIFO: overflow ----
      out_tready = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         set_beat(1'b1, 32'hB0 + 32'(i), 1'b0, 2'd0, 2'd0);
         tick();
         if (i == 8) check("ovf_before", overflow, 1'b0);
      end
      check("ovf_set", overflow, 1'b1);
      check("ovf_count", fifo_count, 4'd8);
      set_beat(1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
      out_tready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_drain%0d", i), out_tdata, 32'hB0 + 32'(i));
         tick();
      end
      check("ovf_drain_tvalid", out_tvalid, 1'b0);
      check("ovf_sticky", overflow, 1'b1);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      check("ovf_clr", overflow, 1'b0);

      // ---- Full FIFO with simultaneous push and pop, pointers wrap ----
      out_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_beat(1'b1, 32'hD0 + 32'(i), 1'b0, 2'd0, 2'd0);
         exp_q.push_back(32'hD0 + 32'(i));
         tick();
      end
      check("full_count", fifo_count, 4'd8);
      out_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         set_beat(1'b1, 32'hE0 + 32'(i), 1'b0, 2'd0, 2'd0);
         check($sformatf("full_head%0d", i), out_tdata, exp_q[0]);
         tick();
         void'(exp_q.pop_front());
         exp_q.push_back(32'hE0 + 32'(i));
         check($sformatf("full_cnt%0d", i), fifo_count, 4'd8);
      end
      check("full_ovf", overflow, 1'b0);
      set_beat(1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("full_drain%0d", i), out_tdata, exp_q[0]);
         void'(exp_q.pop_front());
         tick();
      end
      check("full_drain_count", fifo_count, 4'd0);

      // ---- Asynchronous reset with six beats stored ----
      out_tready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_beat(1'b1, 32'hF0 + 32'(i), 1'b0, 2'd0, 2'd0);
         tick();
      end
      set_beat(1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
      check("arst_pre_count", fifo_count, 4'd6);
      #2;
      axis_rst_n = 1'b0;
      #1;
      check("arst_tvalid", out_tvalid, 1'b0);
      check("arst_fc", fc_tready, 1'b0);
      check("arst_count", fifo_count, 4'd0);
      tick();
      axis_rst_n = 1'b1;
      set_beat(1'b1, 32'hC0C0C0C0, 1'b1, 2'd3, 2'd2);
      tick();
      set_beat(1'b0, 32'h0, 1'b0, 2'd0, 2'd0);
      check("arst_next_tvalid", out_tvalid, 1'b1);
      check("arst_next_data", out_tdata, 32'hC0C0C0C0);
      check("arst_next_count", fifo_count, 4'd1);
      check("arst_next_fc", fc_tready, 1'b1);
      out_tready = 1'b1;
      tick();
      check("arst_final_count", fifo_count, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fsic_is_rx_buffer.md
Name: fsic_is_rx_buffer

Overview:
- Receive-side elastic buffer directly downstream of the IO SERDES Rx path, in the axis_clk domain.
- Accepts the recovered is_as_* stream and stores each beat in a FIFO.
- The SERDES cannot be stalled, so the buffer uses push-only input with no input ready.
- Presents a standard AXI-Stream master to the local AXIS switch. Generates the credit-style flow-control bit (as_is_tready) that the SERDES serialises back to the remote side, so the remote stops sending before this FIFO overflows.

Parameters:
- pDATA_WIDTH, 32, tdata width; tstrb/tkeep are pDATA_WIDTH/8.
- pFIFO_DEPTH, 8, entries; power of two, >=4.
- pFC_THRESHOLD, 3, free-entry count at or below which flow-control ready is deasserted; must cover remote round-trip in-flight beats; must be < pFIFO_DEPTH.

Ports:
- axis_clk  in  1  core clock; all state on posedge.
- axis_rst_n  in  1  asynchronous active-low reset.
- rx_en  in  1  buffer enable; 0 = ignore input pushes.
- in_tdata  in  pDATA_WIDTH  beat data from SERDES Rx.
- in_tstrb  in  pDATA_WIDTH/8  byte strobe.
- in_tkeep  in  pDATA_WIDTH/8  byte keep.
- in_tlast  in  1  end of packet.
- in_tid  in  2  stream id.
- in_tuser  in  2  user bits.
- in_tvalid  in  1  beat present; push request, no ready returned.
- out_tdata / out_tstrb / out_tkeep / out_tlast / out_tid / out_tuser  out  (as inputs)  head-of-FIFO beat.
- out_tvalid  out  1  FIFO non-empty.
- out_tready  in  1  downstream accept.
- fc_tready  out  1  flow-control to SERDES as_is_tready; 1 = remote may send.
- fifo_count  out  $clog2(pFIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky: a beat was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Storage
  - Payload packed as {tlast,tid,tuser,tkeep,tstrb,tdata}, 45 bits at default widths.
  - Circular array addressed by wr_ptr and rd_ptr, each $clog2(pFIFO_DEPTH) bits, wrapping at pFIFO_DEPTH-1 -> 0.
  - Registered count tracks occupancy, 0..pFIFO_DEPTH.
- push_req = in_tvalid & rx_en.
- pop = out_tvalid & out_tready.
- push = push_req & (count < pFIFO_DEPTH | pop), so a full FIFO still accepts a push when a pop occurs in the same cycle.
- Drop: push_req & ~push (full, no pop)
  - Beat discarded; overflow set on the next edge.
  - Pointers and count unchanged.
- Count update: push & ~pop -> +1; pop & ~push -> -1; both or neither -> unchanged.
- Output
  - First-word fall-through: out_* = mem[rd_ptr], combinational from registered storage.
  - out_tvalid = (count != 0).
  - Push-to-out_tvalid latency is 1 cycle; a beat written at edge N is visible after edge N.
  - While out_tvalid=1 and out_tready=0, out_* are held stable (AXIS rule).
- Empty with simultaneous push
  - No bypass; the beat appears the following cycle.
  - A pop cannot occur, since out_tvalid=0.
- Flow control
  - fc_tready is a register.
  - Next value = (pFIFO_DEPTH - count_next) > pFC_THRESHOLD, where count_next is the post-update count.
  - Default thresholds: fc_tready=1 for count_next <= 4, 0 for count_next >= 5.
  - Registered 1 cycle after the count change.
  - When rx_en=0, fc_tready is still computed, so the remote can be allowed while the local side drains.
- Overflow
  - Set by a drop.
  - Cleared by overflow_clr on the next edge; set has priority if both occur in the same cycle.
- Reset (asynchronous, any time, including mid-packet)
  - wr_ptr=rd_ptr=0, count=0, out_tvalid=0, fc_tready=0, overflow=0; storage contents not reset.
  - fc_tready rises on the first clock edge after reset release, because the FIFO is empty.
  - out_* data outputs are don't-care while out_tvalid=0.
- No packet awareness: tlast is carried as payload only, and beats are never reordered or merged.

Test Plan:
- Reset release, in_tvalid=0: out_tvalid=0, fifo_count=0, fc_tready=0, then 1 after the first posedge; overflow=0.
- Push 3 beats 0x11111111/0x22222222/0x33333333 (tlast on 3rd, tid=2, tuser=1), out_tready=1: out_tvalid=1 one cycle after each push; out order preserved; tlast/tid/tuser match; count returns to 0.
- out_tready=0, push 5 consecutive beats: fc_tready drops the cycle after count reaches 5; count=5; out_* stable on beat 1.
- out_tready=0, push 9 beats: 8 stored; 9th dropped; overflow=1; count=8; drain yields beats 1..8 exactly; overflow_clr -> 0.
- Full FIFO (count=8) with simultaneous push and pop: push accepted, no overflow, count stays 8; wr_ptr and rd_ptr wrap to 0 correctly across 2 full cycles of traffic.
- Assert axis_rst_n low with count=6: asynchronously out_tvalid=0, fc_tready=0, count=0; the next beat after release is the first output.
